// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_main_fsm
//  Description : Main control FSM for a multicycle RV32I datapath. Sequences
//                each instruction over several cycles, stalls on the memory
//                ready handshake, traps on unsupported opcodes and counts
//                retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_fsm #(
    parameter logic SUPPORT_ITYPE = 1'b1,
    parameter logic SUPPORT_JAL   = 1'b1,
    parameter logic MEM_WAIT      = 1'b1,
    parameter int   CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Op,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             Branch,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             IllegalOp,
    output logic             InstrRetired,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             w_ready;
    logic             w_retire;

    // Without wait support the memory is assumed to complete every access in one cycle.
    assign w_ready    = MEM_WAIT ? MemReady : 1'b1;
    assign InstrCount = cnt_q;

    // Next-state selection and retirement detection.
    always_comb begin
        state_d  = state_q;
        w_retire = 1'b0;
        case (state_q)
            S_FETCH:    if (w_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    c_OP_LOAD, c_OP_STORE: state_d = S_MEMADR;
                    c_OP_RTYPE:            state_d = S_EXECR;
                    c_OP_ITYPE:            state_d = SUPPORT_ITYPE ? S_EXECI : S_TRAP;
                    c_OP_JAL:              state_d = SUPPORT_JAL ? S_JAL : S_TRAP;
                    c_OP_BEQ:              state_d = S_BEQ;
                    default:               state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (Op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWRITE: begin
                if (w_ready) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB,
            S_BEQ: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register and retired-instruction counter; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (w_retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Immediate format select follows the opcode directly.
    always_comb begin
        case (Op)
            c_OP_STORE: ImmSrc = 2'b01;
            c_OP_BEQ:   ImmSrc = 2'b10;
            c_OP_JAL:   ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    // Moore decode of datapath controls; memory strobes fire only on the accepting cycle.
    always_comb begin
        MemReq       = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCUpdate     = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ALUOp        = 2'b00;
        IllegalOp    = 1'b0;
        InstrRetired = 1'b0;
        if (!reset) begin
            InstrRetired = w_retire;
            case (state_q)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    IRWrite   = w_ready;
                    PCUpdate  = w_ready;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq   = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = w_ready;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB:  RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    PCUpdate = 1'b1;
                end
                S_TRAP:   IllegalOp = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_main_fsm
//  Description : Directed self-checking bench for multicycle_main_fsm. One
//                instance uses default parameters (waits, full opcode
//                support, 16-bit counter); a second has no waits, no
//                jal/I-type support and a 4-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_fsm;

    // Observation vector: {MemReq,AdrSrc,IRWrite,PCUpdate,RegWrite,MemWrite,Branch,
    //                      ALUSrcA,ALUSrcB,ResultSrc,ALUOp,IllegalOp,InstrRetired}
    localparam logic [16:0] E_RST        = {7'b0000000, 8'b00_00_00_00, 2'b00};
    localparam logic [16:0] E_FETCH      = {7'b1011000, 8'b00_10_10_00, 2'b00};
    localparam logic [16:0] E_FETCH_WAIT = {7'b1000000, 8'b00_10_10_00, 2'b00};
    localparam logic [16:0] E_DECODE     = {7'b0000000, 8'b01_01_00_00, 2'b00};
    localparam logic [16:0] E_MEMADR     = {7'b0000000, 8'b10_01_00_00, 2'b00};
    localparam logic [16:0] E_MEMRD      = {7'b1100000, 8'b00_00_00_00, 2'b00};
    localparam logic [16:0] E_MEMWB      = {7'b0000100, 8'b00_00_01_00, 2'b01};
    localparam logic [16:0] E_MEMW_WAIT  = {7'b1100000, 8'b00_00_00_00, 2'b00};
    localparam logic [16:0] E_MEMW_RDY   = {7'b1100010, 8'b00_00_00_00, 2'b01};
    localparam logic [16:0] E_EXECR      = {7'b0000000, 8'b10_00_00_10, 2'b00};
    localparam logic [16:0] E_EXECI      = {7'b0000000, 8'b10_01_00_10, 2'b00};
    localparam logic [16:0] E_ALUWB      = {7'b0000100, 8'b00_00_00_00, 2'b01};
    localparam logic [16:0] E_BEQ        = {7'b0000001, 8'b10_00_00_01, 2'b01};
    localparam logic [16:0] E_JAL        = {7'b0001000, 8'b01_10_00_00, 2'b00};
    localparam logic [16:0] E_TRAP       = {7'b0000000, 8'b00_00_00_00, 2'b10};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [6:0] Op;
    logic       rdy;

    logic        a_req, a_adr, a_irw, a_pcu, a_rw, a_mw, a_br, a_ill, a_ret;
    logic [1:0]  a_sa, a_sb, a_rs, a_ao, a_imm;
    logic [15:0] a_cnt;
    logic        b_req, b_adr, b_irw, b_pcu, b_rw, b_mw, b_br, b_ill, b_ret;
    logic [1:0]  b_sa, b_sb, b_rs, b_ao, b_imm;
    logic [3:0]  b_cnt;
    logic [16:0] obs_a;
    logic [16:0] obs_b;

    int checks   = 0;
    int failures = 0;

    assign obs_a = {a_req, a_adr, a_irw, a_pcu, a_rw, a_mw, a_br, a_sa, a_sb, a_rs, a_ao, a_ill, a_ret};
    assign obs_b = {b_req, b_adr, b_irw, b_pcu, b_rw, b_mw, b_br, b_sa, b_sb, b_rs, b_ao, b_ill, b_ret};

    multicycle_main_fsm dut_a (
        .clk(clk), .reset(rst_a), .Op(Op), .MemReady(rdy),
        .MemReq(a_req), .AdrSrc(a_adr), .IRWrite(a_irw), .PCUpdate(a_pcu),
        .RegWrite(a_rw), .MemWrite(a_mw), .Branch(a_br),
        .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ResultSrc(a_rs), .ALUOp(a_ao), .ImmSrc(a_imm),
        .IllegalOp(a_ill), .InstrRetired(a_ret), .InstrCount(a_cnt)
    );

    multicycle_main_fsm #(
        .SUPPORT_ITYPE(1'b0), .SUPPORT_JAL(1'b0), .MEM_WAIT(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .Op(Op), .MemReady(rdy),
        .MemReq(b_req), .AdrSrc(b_adr), .IRWrite(b_irw), .PCUpdate(b_pcu),
        .RegWrite(b_rw), .MemWrite(b_mw), .Branch(b_br),
        .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ResultSrc(b_rs), .ALUOp(b_ao), .ImmSrc(b_imm),
        .IllegalOp(b_ill), .InstrRetired(b_ret), .InstrCount(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; Op = 7'd0; rdy = 1'b1;
        tick(); tick();
        #1 chk("a_rst_outs", obs_a, E_RST); chk("a_rst_cnt", a_cnt, 0); chk("a_rst_imm", a_imm, 0);
        chk("b_rst_outs", obs_b, E_RST);

        // lw, always ready: 5 cycles
        rst_a = 1'b0; Op = OP_LW;
        #1 chk("lw_fetch", obs_a, E_FETCH);
        tick(); #1 chk("lw_decode", obs_a, E_DECODE);
        tick(); #1 chk("lw_memadr", obs_a, E_MEMADR);
        tick(); #1 chk("lw_memread", obs_a, E_MEMRD);
        tick(); #1 chk("lw_memwb", obs_a, E_MEMWB); chk("lw_cnt_pre", a_cnt, 0);
        tick(); #1 chk("lw_cnt", a_cnt, 1); chk("lw_next_fetch", obs_a, E_FETCH);

        // fetch stall, then sw with 3 wait cycles in MEMWRITE
        rdy = 1'b0; Op = OP_SW;
        #1 chk("sw_fetch_wait", obs_a, E_FETCH_WAIT); chk("sw_imm", a_imm, 2'b01);
        tick(); rdy = 1'b1;
        #1 chk("sw_fetch", obs_a, E_FETCH);
        tick(); #1 chk("sw_decode", obs_a, E_DECODE);
        tick(); #1 chk("sw_memadr", obs_a, E_MEMADR);
        tick();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            #1 chk("sw_wait", obs_a, E_MEMW_WAIT);
            tick();
        end
        rdy = 1'b1;
        #1 chk("sw_accept", obs_a, E_MEMW_RDY);
        tick(); #1 chk("sw_cnt", a_cnt, 2); chk("sw_next_fetch", obs_a, E_FETCH);

        // R-type then beq back to back
        Op = OP_R;
        tick(); #1 chk("r_decode", obs_a, E_DECODE);
        tick(); #1 chk("r_execr", obs_a, E_EXECR);
        tick(); #1 chk("r_aluwb", obs_a, E_ALUWB);
        tick(); Op = OP_BEQ;
        #1 chk("beq_fetch", obs_a, E_FETCH); chk("beq_imm", a_imm, 2'b10); chk("r_cnt", a_cnt, 3);
        tick(); #1 chk("beq_decode", obs_a, E_DECODE);
        tick(); #1 chk("beq_state", obs_a, E_BEQ);
        tick(); #1 chk("beq_cnt", a_cnt, 4);

        // I-type
        Op = OP_I;
        tick(); #1 chk("i_decode", obs_a, E_DECODE);
        tick(); #1 chk("i_execi", obs_a, E_EXECI);
        tick(); #1 chk("i_aluwb", obs_a, E_ALUWB);
        tick(); #1 chk("i_cnt", a_cnt, 5);

        // jal; MemReady low while no request is outstanding must be ignored
        Op = OP_JAL;
        #1 chk("jal_imm", a_imm, 2'b11);
        tick(); rdy = 1'b0;
        #1 chk("jal_decode", obs_a, E_DECODE);
        tick(); #1 chk("jal_state", obs_a, E_JAL);
        tick(); #1 chk("jal_aluwb", obs_a, E_ALUWB);
        rdy = 1'b1;
        tick(); #1 chk("jal_cnt", a_cnt, 6);

        // reset while lw is stalled in MEMREAD
        Op = OP_LW;
        tick(); tick(); tick(); rdy = 1'b0;
        #1 chk("rst_mr_memread", obs_a, E_MEMRD);
        tick(); #1 chk("rst_mr_held", obs_a, E_MEMRD);
        rst_a = 1'b1;
        #1 chk("rst_mr_forced", obs_a, E_RST);
        tick(); #1 chk("rst_mr_cnt", a_cnt, 0);
        rst_a = 1'b0; rdy = 1'b1;
        #1 chk("rst_mr_fetch", obs_a, E_FETCH);

        // illegal opcode traps and holds until reset
        Op = OP_BAD;
        tick(); #1 chk("bad_decode", obs_a, E_DECODE);
        tick();
        for (int i = 0; i < 12; i++) begin
            rdy = i[0];
            #1 chk("bad_trap", obs_a, E_TRAP);
            tick();
        end
        rst_a = 1'b1; rdy = 1'b1;
        tick(); rst_a = 1'b0;
        #1 chk("bad_recover", obs_a, E_FETCH); chk("bad_cnt", a_cnt, 0);

        // second instance: MemReady ignored, jal/I-type unsupported, 4-bit counter
        rst_a = 1'b1; rst_b = 1'b0; rdy = 1'b0; Op = OP_LW;
        #1 chk("b_lw_fetch", obs_b, E_FETCH);
        tick(); #1 chk("b_lw_decode", obs_b, E_DECODE);
        tick(); #1 chk("b_lw_memadr", obs_b, E_MEMADR);
        tick(); #1 chk("b_lw_memread", obs_b, E_MEMRD);
        tick(); #1 chk("b_lw_memwb", obs_b, E_MEMWB);
        tick(); #1 chk("b_lw_cnt", b_cnt, 1);
        Op = OP_SW;
        tick(); tick(); tick();
        #1 chk("b_sw_accept", obs_b, E_MEMW_RDY);
        tick(); #1 chk("b_sw_cnt", b_cnt, 2);
        Op = OP_JAL;
        tick(); tick(); #1 chk("b_jal_trap", obs_b, E_TRAP);
        tick(); #1 chk("b_jal_trap_hold", obs_b, E_TRAP);
        rst_b = 1'b1;
        tick(); #1 chk("b_rst_cnt", b_cnt, 0);
        rst_b = 1'b0; Op = OP_I;
        tick(); tick(); #1 chk("b_i_trap", obs_b, E_TRAP);
        rst_b = 1'b1;
        tick(); rst_b = 1'b0; Op = OP_R;
        #1 chk("b_wrap_start", b_cnt, 0);
        for (int i = 1; i <= 17; i++) begin
            tick(); tick(); tick();
            #1 chk("b_wrap_aluwb", obs_b, E_ALUWB);
            tick();
            #1 chk("b_wrap_cnt", {28'd0, b_cnt}, i % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Control state machine for the multicycle RV32I datapath. It replaces the single-cycle main decoder with a registered controller that sequences each instruction over several cycles. The controller drives all datapath mux selects and write strobes, and can stall on a memory ready handshake. It traps on unsupported opcodes and counts retired instructions. It sits beside the ALU decoder, which consumes `ALUOp`, and feeds the shared instruction/data memory port.

## Interface
- `SUPPORT_ITYPE`, 1: when 1, opcode 0010011 (I-type ALU) is executed; when 0, it traps.
- `SUPPORT_JAL`, 1: when 1, opcode 1101111 (jal) is executed; when 0, it traps.
- `MEM_WAIT`, 1: when 1, memory states wait for `MemReady`; when 0, `MemReady` is ignored and treated as 1.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `Op` input 7: opcode field of the instruction register.
- `MemReady` input 1: memory has completed the current access this cycle.
- `MemReq` output 1: a memory access is requested.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALU result register.
- `IRWrite`, `PCUpdate`, `RegWrite`, `MemWrite`, `Branch` output 1 each: write and update strobes.
- `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ALUOp`, `ImmSrc` output 2 each: datapath mux and decode selects.
- `IllegalOp` output 1: set in the TRAP state.
- `InstrRetired` output 1: one-cycle pulse on the last cycle of an instruction.
- `InstrCount` output `CNT_W`: count of retired instructions; wraps modulo 2^`CNT_W`.

## Operation
- **State register.** States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- **Output style.** All outputs except `ImmSrc` are decoded from the state. The strobes `IRWrite`, `PCUpdate` in FETCH and `MemWrite` are additionally ANDed with the effective `MemReady`.
- **ImmSrc.** Combinational from `Op`:
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 1101111 gives 11.
  - All other opcodes give 00.
- **Default values.** Any output not listed for a state is 0.
- **FETCH:** `MemReq`=1, `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `PCUpdate`=1. Goes to DECODE when ready; otherwise holds.
- **DECODE:** `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00. Next state by `Op`:
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI (if `SUPPORT_ITYPE`).
  - 1101111 goes to JAL (if `SUPPORT_JAL`).
  - 1100011 goes to BEQ.
  - Any other opcode goes to TRAP.
- **MEMADR:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. `Op`=0000011 goes to MEMREAD; otherwise goes to MEMWRITE.
- **MEMREAD:** `MemReq`=1, `AdrSrc`=1, `ResultSrc`=00. Goes to MEMWB when ready; otherwise holds.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1. Retires; goes to FETCH.
- **MEMWRITE:** `MemReq`=1, `AdrSrc`=1, `MemWrite`=1. Retires and goes to FETCH when ready; otherwise holds.
- **EXECR:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Goes to ALUWB.
- **EXECI:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Goes to ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1. Retires; goes to FETCH.
- **BEQ:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `Branch`=1. Retires; goes to FETCH.
- **JAL:** `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCUpdate`=1. Goes to ALUWB.
- **TRAP:** `IllegalOp`=1 and all strobes 0. Held until `reset`.
- **Retirement.** `InstrRetired`=1 in each retiring cycle. `InstrCount` increments by 1 on that edge and wraps from all-ones to 0.

## Timing
- **Reset.** While `reset`=1 on an edge, state becomes FETCH and `InstrCount` becomes 0. While `reset` is high:
  - All strobes, `MemReq`, `IllegalOp` and `InstrRetired` are forced to 0.
  - `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ALUOp` and `AdrSrc` are 0.
- **Reset mid-instruction.** A reset in any state, including a held memory state or TRAP, abandons the instruction. No retire is counted. FETCH begins on the first cycle after `reset` falls.
- **Latency with `MEM_WAIT`=0 (or `MemReady` always 1):**
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- **Memory wait.** Each cycle with `MemReady`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - `MemReq` stays high throughout the wait, and the selects stay stable.
  - `IRWrite`, `PCUpdate` and `MemWrite` pulse exactly once, in the accepting cycle.
- **Handshake ordering.** `MemReady` sampled while `MemReq`=0 is ignored.
- **Op stability.** `Op` is required stable from the FETCH accept edge until the instruction retires. The IR holds it.

## Test plan
- **lw, `MEM_WAIT`=0.** `Op`=0000011 after reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `RegWrite`=1 only in cycle 5 with `ResultSrc`=01. `InstrCount` goes 0 -> 1.
- **sw with 3 wait cycles.** `Op`=0100011, `MemReady` low for 3 cycles in MEMWRITE -> `MemReq` high for 4 cycles. `MemWrite` pulses only in the 4th. `ImmSrc`=01. Retire takes 7 cycles in total.
- **R-type then beq back-to-back.** -> `ALUOp`=10 in EXECR. BEQ shows `ALUOp`=01 and `Branch`=1. Total 7 cycles; `InstrCount`=2.
- **Illegal opcode.** `Op`=1111111 -> TRAP after DECODE and `IllegalOp`=1, held for 10+ cycles with no strobes. `reset` -> FETCH and `IllegalOp`=0.
- **`SUPPORT_JAL`=0.** `Op`=1101111 -> TRAP. **`SUPPORT_JAL`=1:** JAL then ALUWB, with `PCUpdate` in the JAL state and `ImmSrc`=11.
- **`CNT_W`=4.** 17 retired R-types -> `InstrCount` reads 15, then 0, then 1. Asserting `reset` in MEMREAD -> count 0, no `RegWrite` issued.
